qrs_detector: RTL
=================

# qrs_detector

Downstream consumer of the smoothing FIR stage. Takes the filtered, signed single-lead EKG sample stream with its valid strobe and detects R-peaks with a threshold-crossing state machine and a refractory window. For every beat it reports the peak amplitude and the R-R interval in samples, and it flags asystole when no beat arrives within a configurable window. Its outputs feed the heart-rate/BPM computation and display logic.

## Interface
- DATA_RESOLUTION, 8: sample width in bits; matches the FIR output width.
- RR_WIDTH, 12: width of the R-R interval and internal sample counters.
- REFRACTORY_SAMPLES, 50: number of valid samples ignored after each declared beat (200 ms at 250 Hz).
- MAX_RR_SAMPLES, 750: saturation and asystole limit in samples. Must be below 2^RR_WIDTH.
- clk_in  in  1  single system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- signed_data_in  in  DATA_RESOLUTION  filtered signed sample (lead 0).
- data_valid_in  in  1  qualifies signed_data_in for one cycle.
- threshold_in  in  DATA_RESOLUTION  signed detection threshold, sampled with each valid sample.
- beat_out  out  1  one-cycle pulse per declared beat.
- peak_amplitude_out  out  DATA_RESOLUTION  signed maximum of the last beat; holds until the next beat.
- rr_interval_out  out  RR_WIDTH  samples between the last two peaks; holds until the next beat.
- rr_valid_out  out  1  pulses with beat_out when rr_interval_out is meaningful.
- asystole_out  out  1  level; high while no beat has occurred for MAX_RR_SAMPLES samples.

## Operation
- All state advances only on cycles with data_valid_in=1. Gaps between valid samples have no effect on state or counters.
- `elapsed` counts valid samples since the last declared peak and saturates at MAX_RR_SAMPLES. The current sample has index k = min(elapsed+1, MAX_RR_SAMPLES).
- `above` = (signed_data_in > threshold_in), using a signed compare. `prev_above` holds `above` from the previous valid sample.
- SEARCH:
  - If above && !prev_above, go to TRACK, set peak_val = x, set cand = k.
  - Otherwise, elapsed <= k.
- TRACK:
  - If x > peak_val (strictly greater), update peak_val = x and cand = k. A tie keeps the earlier peak.
  - If !above, declare a beat: register the outputs, set elapsed <= k - cand, load the refractory counter, and go to REFRACTORY.
- REFRACTORY:
  - Count REFRACTORY_SAMPLES valid samples after the declaring sample, ignoring the threshold. elapsed keeps incrementing.
  - Then go to SEARCH. The rising-edge requirement means a signal still above threshold cannot retrigger until it dips.
- rr_valid_out = 1 only when a previous beat exists since reset and the interval did not saturate (asystole_out was 0 at the declare).
- The first beat after reset, and the first beat after asystole, give beat_out=1 and rr_valid_out=0.
- asystole_out:
  - Set when elapsed reaches MAX_RR_SAMPLES.
  - Cleared on the next declared beat.
  - cand also saturates at MAX_RR_SAMPLES.

## Timing
- Reset values:
  - Outputs: beat_out, rr_valid_out, asystole_out, peak_amplitude_out, and rr_interval_out are all 0.
  - Internal: state SEARCH, elapsed 0, prev_above 0, no previous beat.
- Reset is asynchronous. Asserting it mid-TRACK or mid-REFRACTORY clears the block immediately, and no beat is emitted.
- Latency is 1 cycle: beat_out, rr_valid_out, peak_amplitude_out, and rr_interval_out update on the clock edge after the declaring sample is accepted.
- asystole_out rises on the edge that accepts the sample making elapsed equal MAX_RR_SAMPLES.
- Back-to-back valid samples are supported every cycle. No backpressure is applied.

## Structure
- A shared package `ekg_pkg` holds:
  - typedef qrs_state_t {SEARCH, TRACK, REFRACTORY}
  - the default sample rate constant
- One sub-module, `sat_counter` (load, increment-on-enable, saturate at a limit), is instantiated for elapsed and for the refractory count.

## Test plan
Bench parameters: REFRACTORY_SAMPLES=3, MAX_RR_SAMPLES=32, threshold_in=20.

1. Single pulse.
   - Stimulus: valid samples 0, 30, 50, 40, 10.
   - Required: beat_out one cycle after the 10 is accepted; peak_amplitude_out=50; rr_valid_out=0.
2. Second pulse.
   - Stimulus: continue from scenario 1 with 0, 0, 0, 0, 0, 0, 30, 60, 10.
   - Required: beat_out=1, peak_amplitude_out=60, rr_interval_out=10, rr_valid_out=1.
3. Refractory window.
   - Stimulus: after a beat, samples 0, 40, 0, then 0, 40, 0.
   - Required: the first 40 (inside refractory) is ignored; exactly one beat is declared, from the second 40.
4. No retrigger while high.
   - Stimulus: after a beat, 10 samples of 40.
   - Required: no beat_out until a sample ≤20 is followed by a crossing.
5. Asystole.
   - Stimulus: 32 zero samples after a beat.
   - Required: asystole_out=1 after the 32nd. A following pulse gives beat_out=1, rr_valid_out=0, and asystole_out returns to 0.
6. Valid gaps and reset.
   - Stimulus: repeat scenario 2 with data_valid_in low on alternate cycles.
   - Required: identical rr_interval_out=10.
   - Then: assert rst_in low mid-TRACK. Required: all outputs 0 immediately and no beat after release.

Source files
------------

// File: rtl/ekg_pkg.sv
// Shared EKG definitions: detector state encoding and the nominal sample rate.
package ekg_pkg;

   typedef enum logic [1:0] {
      SEARCH,
      TRACK,
      REFRACTORY
   } qrs_state_t;

   // Nominal acquisition rate; refractory and R-R limits are expressed in samples at this rate.
   localparam int SAMPLE_RATE_HZ = 250;

endpackage

// File: rtl/qrs_detector_if.sv
// Sample stream into the QRS detector and the beat report coming out of it.
interface qrs_detector_if #(
   parameter int DATA_RESOLUTION = 8,
   parameter int RR_WIDTH        = 12
);

   logic signed [DATA_RESOLUTION-1:0] signed_data_in;
   logic                              data_valid_in;
   logic signed [DATA_RESOLUTION-1:0] threshold_in;
   logic                              beat_out;
   logic signed [DATA_RESOLUTION-1:0] peak_amplitude_out;
   logic        [RR_WIDTH-1:0]        rr_interval_out;
   logic                              rr_valid_out;
   logic                              asystole_out;

   // Upstream side: the FIR stage and threshold source feed samples, the BPM logic reads beats.
   modport master (
      output signed_data_in, data_valid_in, threshold_in,
      input  beat_out, peak_amplitude_out, rr_interval_out, rr_valid_out, asystole_out
   );

   // Detector side.
   modport slave (
      input  signed_data_in, data_valid_in, threshold_in,
      output beat_out, peak_amplitude_out, rr_interval_out, rr_valid_out, asystole_out
   );

endinterface

// File: rtl/qrs_detector_sat_counter.sv
// Loadable up-counter that stops at LIMIT; load wins over increment.
module sat_counter #(
   parameter int WIDTH = 12,
   parameter int LIMIT = 750
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

   // Count register: load, else saturating increment on enable.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count < LIM)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/qrs_detector.sv
// R-peak detector: threshold-crossing FSM with refractory window, R-R interval and asystole flag.
module qrs_detector
   import ekg_pkg::*;
#(
   parameter int DATA_RESOLUTION    = 8,
   parameter int RR_WIDTH           = 12,
   parameter int REFRACTORY_SAMPLES = 50,
   parameter int MAX_RR_SAMPLES     = 750
) (
   input  logic           clk_in,
   input  logic           rst_in,
   qrs_detector_if.slave  bus
);

   localparam logic [RR_WIDTH-1:0] MAX_RR    = RR_WIDTH'(MAX_RR_SAMPLES);
   localparam logic [RR_WIDTH-1:0] REFR_LAST = RR_WIDTH'(REFRACTORY_SAMPLES - 1);

   qrs_state_t                        state_q, state_d;
   logic signed [DATA_RESOLUTION-1:0] x, thr;
   logic signed [DATA_RESOLUTION-1:0] peak_q;
   logic        [RR_WIDTH-1:0]        cand_q;
   logic        [RR_WIDTH-1:0]        elapsed, refr_cnt, k;
   logic                              valid, above, prev_above_q, have_prev_q;
   logic                              start, upd, declare;

   logic                              beat_p1, rr_vld_p1, asystole_p1;
   logic signed [DATA_RESOLUTION-1:0] peak_p1;
   logic        [RR_WIDTH-1:0]        rr_p1;

   assign x     = bus.signed_data_in;
   assign thr   = bus.threshold_in;
   assign valid = bus.data_valid_in;
   assign above = x > thr;
   // Index of the current sample relative to the last peak, pinned at the asystole limit.
   assign k     = (elapsed >= MAX_RR) ? MAX_RR : elapsed + RR_WIDTH'(1);

   // Samples since the last peak; re-based to the peak position when a beat is declared.
   sat_counter #(.WIDTH(RR_WIDTH), .LIMIT(MAX_RR_SAMPLES)) u_elapsed (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .load     (declare),
      .load_val (k - cand_q),
      .en       (valid),
      .count    (elapsed)
   );

   // Samples consumed inside the refractory window.
   sat_counter #(.WIDTH(RR_WIDTH), .LIMIT(REFRACTORY_SAMPLES)) u_refr (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .load     (declare),
      .load_val ('0),
      .en       (valid && (state_q == REFRACTORY)),
      .count    (refr_cnt)
   );

   // Next-state and event decode; nothing moves without a valid sample.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      upd     = 1'b0;
      declare = 1'b0;
      if (valid) begin
         case (state_q)
            SEARCH: begin
               if (above && !prev_above_q) begin
                  start   = 1'b1;
                  state_d = TRACK;
               end
            end
            TRACK: begin
               // A falling sample is at or below threshold, so it can never also be a new maximum.
               if (x > peak_q) upd = 1'b1;
               if (!above) begin
                  declare = 1'b1;
                  state_d = REFRACTORY;
               end
            end
            REFRACTORY: begin
               if (refr_cnt >= REFR_LAST) state_d = SEARCH;
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= SEARCH;
      else         state_q <= state_d;
   end

   // Candidate peak tracking and previous-sample threshold memory.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         peak_q       <= '0;
         cand_q       <= '0;
         prev_above_q <= 1'b0;
      end else if (valid) begin
         prev_above_q <= above;
         if (start || upd) begin
            peak_q <= x;
            cand_q <= k;
         end
      end
   end

   // Beat report register stage: one cycle after the declaring sample.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         beat_p1     <= 1'b0;
         rr_vld_p1   <= 1'b0;
         asystole_p1 <= 1'b0;
         peak_p1     <= '0;
         rr_p1       <= '0;
         have_prev_q <= 1'b0;
      end else begin
         beat_p1   <= declare;
         rr_vld_p1 <= declare && have_prev_q && !asystole_p1;
         if (declare) begin
            peak_p1     <= peak_q;
            rr_p1       <= cand_q;
            have_prev_q <= 1'b1;
            asystole_p1 <= 1'b0;
         end else if (valid && (k == MAX_RR)) begin
            asystole_p1 <= 1'b1;
         end
      end
   end

   assign bus.beat_out           = beat_p1;
   assign bus.rr_valid_out       = rr_vld_p1;
   assign bus.asystole_out       = asystole_p1;
   assign bus.peak_amplitude_out = peak_p1;
   assign bus.rr_interval_out    = rr_p1;

endmodule
